sram_access_arbiter: RTL and testbench
======================================

// Module: sram_access_arbiter
// PURPOSE
//  Shares the single off-chip SRAM port between the instruction-fetch requester (read-only)
//  and the MEM-stage data requester (read/write). Sequences each multi-cycle SRAM access
//  with an FSM and returns a one-cycle ack with read data. Produces per-port ready signals
//  that drive the pipeline freeze logic.
// PARAMETERS
//  SRAM_WAIT    4   SRAM access cycles per transfer; legal range 2..15
//  STARVE_LIMIT 3   maximum consecutive data grants while a fetch is pending; legal range >= 1
// PORTS
//  clk        input  1   clock, rising edge
//  rst        input  1   reset, synchronous, active-low
//  if_req     input  1   fetch request; held with if_addr until if_ack
//  if_addr    input  32  fetch byte address
//  if_ack     output 1   one-cycle pulse; if_rdata valid in the same cycle
//  if_rdata   output 32  fetch read data, registered
//  if_ready   output 1   ~if_req | if_ack (combinational)
//  mem_req    input  1   data request; held with mem_we, mem_addr and mem_wdata until mem_ack
//  mem_we     input  1   1 = write, 0 = read
//  mem_addr   input  32  data byte address
//  mem_wdata  input  32  write data
//  mem_ack    output 1   one-cycle pulse; mem_rdata valid for reads
//  mem_rdata  output 32  data read data, registered
//  mem_ready  output 1   ~mem_req | mem_ack (combinational)
//  SRAM_Addr  output 19  SRAM word address = granted addr[20:2]
//  SRAM_WE_N  output 1   SRAM write enable, active-low
//  SRAM_DQ    inout  32  SRAM data bus; high-Z unless a write is in ACCESS
// BEHAVIOUR
//  - Reset (rst = 0 at an edge): state IDLE; acks 0; rdata regs 0; SRAM_WE_N 1;
//    SRAM_Addr 0; DQ high-Z; starve_cnt 0. Reset during an access aborts it; no ack is issued.
//  - FSM states: IDLE, ACCESS, DONE.
//  - IDLE: if any request is pending, latch grant, addr, we and wdata; go to ACCESS with
//    cnt = SRAM_WAIT-1. Otherwise stay in IDLE.
//  - ACCESS: SRAM_Addr = latched addr[20:2].
//    - Write: DQ driven with wdata for all ACCESS cycles. SRAM_WE_N = 0 while cnt != 0;
//      SRAM_WE_N = 1 on the final cycle (cnt == 0) for hold.
//    - Read: SRAM_WE_N = 1; DQ high-Z.
//    - At cnt == 0: a read captures SRAM_DQ into the granted port's rdata register; go to DONE.
//      Otherwise decrement cnt.
//  - DONE: assert the granted port's ack for exactly one cycle; DQ high-Z; SRAM_WE_N 1; go to IDLE.
//  - Latency: request present in IDLE at cycle 0 -> ack at cycle SRAM_WAIT+1.
//    Minimum issue interval is SRAM_WAIT+2 cycles (one IDLE bubble).
//  - A request still high in the IDLE cycle after its ack is treated as a new access.
//  - Arbitration is evaluated in IDLE only. Data has priority over fetch, except that fetch
//    wins when starve_cnt == STARVE_LIMIT and if_req = 1.
//  - starve_cnt: +1 on each data grant while if_req = 1; cleared on any fetch grant;
//    saturates at STARVE_LIMIT.
//  - Input changes while not in IDLE are ignored because all access fields are latched.
//  - The non-granted port's ack stays 0, and its rdata register holds its previous value.
// STRUCTURE
//  - Shared package arm_mem_pkg: state enum {IDLE, ACCESS, DONE}, GNT_IF/GNT_MEM constants,
//    SRAM_AW = 19, SRAM_DW = 32.
//  - Sub-module sram_grant_select: combinational priority decision plus the starve_cnt
//    register. The top level holds the FSM, wait counter, latches and tristate.
// TESTING (SRAM_WAIT = 4, STARVE_LIMIT = 2 unless noted; SRAM behavioural model with 4-cycle read)
//  - Fetch read: if_req at cycle 0, if_addr 0x10 -> SRAM_Addr = 0x004 in cycles 1-4,
//    SRAM_WE_N = 1 throughout, if_ack = 1 only at cycle 5, if_rdata = model[4].
//  - Data write: mem_we = 1, mem_addr 0x400, wdata 0xDEADBEEF -> SRAM_Addr 0x100;
//    SRAM_WE_N = 0 in cycles 1-3 and 1 in cycle 4; DQ = 0xDEADBEEF in cycles 1-4 and high-Z
//    from cycle 5; mem_ack at cycle 5; model[0x100] updated.
//  - Simultaneous requests at cycle 0 -> mem_ack at cycle 5, if_ack at cycle 11;
//    if_ready = 0 in cycles 0-10.
//  - Starvation: both requests held continuously -> grant order D, D, F, D, D, F;
//    if_ack never more than 3 transfers apart.
//  - rst = 0 in cycle 2 of a write -> from the next cycle SRAM_WE_N = 1, DQ high-Z, no ack;
//    a fresh read after reset returns correct data.
//  - Back-to-back reads on the data port with mem_req held -> acks spaced exactly 6 cycles
//    apart, each with its own address's data.

Source files
------------

// File: rtl/arm_mem_pkg.sv
// Shared types and constants for the SRAM access arbiter: FSM states, grant
// encodings and SRAM bus geometry.
package arm_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_e;

  localparam logic GNT_IF  = 1'b0;
  localparam logic GNT_MEM = 1'b1;

  localparam int SRAM_AW = 19;
  localparam int SRAM_DW = 32;

  // Byte address to SRAM word address.
  function automatic logic [SRAM_AW-1:0] word_addr(input logic [31:0] byte_addr);
    return byte_addr[20:2];
  endfunction

endpackage

// File: rtl/sram_access_arbiter_grant_select.sv
// Priority decision between fetch and data requesters, with the fetch
// starvation counter that forces a fetch grant after a run of data grants.
module sram_grant_select
  import arm_mem_pkg::*;
#(
  parameter int STARVE_LIMIT = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req_i,
  input  logic mem_req_i,
  input  logic grant_en_i,
  output logic grant_o,
  output logic any_req_o
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_cnt_q;
  logic [CW-1:0] starve_cnt_d;
  logic          fetch_forced_s;

  // Data wins by default; a pending fetch wins once it has waited long enough.
  always_comb begin
    any_req_o      = if_req_i | mem_req_i;
    fetch_forced_s = if_req_i && (starve_cnt_q == LIMIT);
    if (fetch_forced_s || !mem_req_i) begin
      grant_o = GNT_IF;
    end else begin
      grant_o = GNT_MEM;
    end
  end

  // Starvation counter next state, updated only when a grant is issued.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (grant_en_i && any_req_o) begin
      if (grant_o == GNT_IF) begin
        starve_cnt_d = '0;
      end else if (if_req_i && (starve_cnt_q != LIMIT)) begin
        starve_cnt_d = starve_cnt_q + CW'(1);
      end else begin
        starve_cnt_d = starve_cnt_q;
      end
    end else begin
      starve_cnt_d = starve_cnt_q;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: rtl/sram_access_arbiter.sv
// Shares one off-chip SRAM port between instruction fetch (read-only) and the
// MEM-stage data port, sequencing each multi-cycle access with an FSM.
module sram_access_arbiter
  import arm_mem_pkg::*;
#(
  parameter int SRAM_WAIT    = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 if_req,
  input  logic [31:0]          if_addr,
  output logic                 if_ack,
  output logic [31:0]          if_rdata,
  output logic                 if_ready,
  input  logic                 mem_req,
  input  logic                 mem_we,
  input  logic [31:0]          mem_addr,
  input  logic [31:0]          mem_wdata,
  output logic                 mem_ack,
  output logic [31:0]          mem_rdata,
  output logic                 mem_ready,
  output logic [SRAM_AW-1:0]   SRAM_Addr,
  output logic                 SRAM_WE_N,
  inout  wire  [SRAM_DW-1:0]   SRAM_DQ
);

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SRAM_WAIT - 1);

  arb_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 gnt_q, gnt_d;
  logic                 we_q, we_d;
  logic [SRAM_AW-1:0]   addr_q, addr_d;
  logic [SRAM_DW-1:0]   wdata_q, wdata_d;
  logic                 if_ack_q, if_ack_d;
  logic                 mem_ack_q, mem_ack_d;
  logic [SRAM_DW-1:0]   if_rdata_q, if_rdata_d;
  logic [SRAM_DW-1:0]   mem_rdata_q, mem_rdata_d;
  logic                 we_n_q, we_n_d;
  logic                 oe_q, oe_d;

  logic                 grant_s;
  logic                 any_req_s;
  logic                 grant_en_s;
  logic                 sel_we_s;
  logic                 unused_addr_s;

  assign grant_en_s    = (state_q == IDLE);
  assign unused_addr_s = ^{if_addr[31:21], if_addr[1:0], mem_addr[31:21], mem_addr[1:0]};

  sram_grant_select #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_grant_select (
    .clk        (clk),
    .rst        (rst),
    .if_req_i   (if_req),
    .mem_req_i  (mem_req),
    .grant_en_i (grant_en_s),
    .grant_o    (grant_s),
    .any_req_o  (any_req_s)
  );

  // FSM, wait counter and access-field latches; pin controls are computed one
  // cycle ahead so SRAM_WE_N and the DQ enable come straight from flops.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gnt_d       = gnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if_ack_d    = 1'b0;
    mem_ack_d   = 1'b0;
    we_n_d      = 1'b1;
    oe_d        = 1'b0;
    sel_we_s    = (grant_s == GNT_MEM) && mem_we;

    case (state_q)
      IDLE: begin
        if (any_req_s) begin
          state_d = ACCESS;
          cnt_d   = CNT_INIT;
          gnt_d   = grant_s;
          we_d    = sel_we_s;
          we_n_d  = ~sel_we_s;
          oe_d    = sel_we_s;
          if (grant_s == GNT_MEM) begin
            addr_d  = word_addr(mem_addr);
            wdata_d = mem_wdata;
          end else begin
            addr_d  = word_addr(if_addr);
            wdata_d = wdata_q;
          end
        end else begin
          state_d = IDLE;
        end
      end

      ACCESS: begin
        if (cnt_q == {CNT_W{1'b0}}) begin
          state_d = DONE;
          if (!we_q && (gnt_q == GNT_IF)) begin
            if_rdata_d = SRAM_DQ;
          end else if (!we_q) begin
            mem_rdata_d = SRAM_DQ;
          end else begin
            if_rdata_d = if_rdata_q;
          end
          if (gnt_q == GNT_IF) begin
            if_ack_d = 1'b1;
          end else begin
            mem_ack_d = 1'b1;
          end
        end else begin
          cnt_d  = cnt_q - CNT_W'(1);
          // Release WE one cycle early so data is held past the write strobe.
          we_n_d = ~(we_q && (cnt_q != CNT_W'(1)));
          oe_d   = we_q;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      gnt_q       <= GNT_IF;
      we_q        <= 1'b0;
      addr_q      <= {SRAM_AW{1'b0}};
      wdata_q     <= {SRAM_DW{1'b0}};
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
      if_rdata_q  <= {SRAM_DW{1'b0}};
      mem_rdata_q <= {SRAM_DW{1'b0}};
      we_n_q      <= 1'b1;
      oe_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      if_ack_q    <= if_ack_d;
      mem_ack_q   <= mem_ack_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      we_n_q      <= we_n_d;
      oe_q        <= oe_d;
    end
  end

  assign if_ack    = if_ack_q;
  assign mem_ack   = mem_ack_q;
  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;
  assign if_ready  = ~if_req | if_ack_q;
  assign mem_ready = ~mem_req | mem_ack_q;
  assign SRAM_Addr = addr_q;
  assign SRAM_WE_N = we_n_q;
  assign SRAM_DQ   = oe_q ? wdata_q : {SRAM_DW{1'bz}};

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Directed bench for sram_access_arbiter: expected acks go into a scoreboard
// queue; a monitor pops and compares them whenever the DUT acks.
module tb_sram_access_arbiter;

  localparam int SRAM_WAIT    = 4;
  localparam int STARVE_LIMIT = 2;
  localparam logic [31:0] PAT = 32'h5A5A_A5A5;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_ack, if_ready;
  logic [31:0] if_addr, if_rdata;
  logic        mem_req, mem_we, mem_ack, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [18:0] sram_addr;
  logic        sram_we_n;
  wire  [31:0] sram_dq;

  logic        tb_drv, tb_pat, mdl_clr;
  logic [31:0] tb_val;
  logic [31:0] mdl_mem [0:1023];

  int cyc   = 0;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        is_if;
    logic        chk_data;
    logic [31:0] data;
    int          at;
  } exp_t;
  exp_t sb_q[$];

  sram_access_arbiter #(
    .SRAM_WAIT    (SRAM_WAIT),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ack    (if_ack),
    .if_rdata  (if_rdata),
    .if_ready  (if_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .SRAM_Addr (sram_addr),
    .SRAM_WE_N (sram_we_n),
    .SRAM_DQ   (sram_dq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(input int i);
    return {16'hC0DE, 16'(i)};
  endfunction

  // SRAM model: word i powers up as 0xC0DE_00ii; writes land while WE_N is low.
  always @(posedge clk) begin
    if (mdl_clr) begin
      for (int i = 0; i < 1024; i++) mdl_mem[i] <= init_word(i);
    end else if (!sram_we_n) begin
      mdl_mem[sram_addr[9:0]] <= sram_dq;
    end
  end

  always_comb tb_val = tb_pat ? PAT : mdl_mem[sram_addr[9:0]];
  assign sram_dq = tb_drv ? tb_val : 32'bz;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input logic is_if, input logic chk, input logic [31:0] d, input int at);
    exp_t e;
    e.is_if = is_if;
    e.chk_data = chk;
    e.data = d;
    e.at = at;
    sb_q.push_back(e);
  endtask

  task automatic next_drive();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every ack must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst === 1'b1 && (if_ack || mem_ack)) begin
      if (sb_q.size() == 0) begin
        check("unexpected_ack", {30'd0, if_ack, mem_ack}, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("ack_port_if", {31'd0, if_ack}, {31'd0, e.is_if});
        check("ack_port_mem", {31'd0, mem_ack}, {31'd0, ~e.is_if});
        check("ack_cycle", 32'(cyc), 32'(e.at));
        if (e.chk_data) check("ack_rdata", e.is_if ? if_rdata : mem_rdata, e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0;
    int nack;
    rst = 1'b0; mdl_clr = 1'b1; tb_drv = 1'b1; tb_pat = 1'b1;
    if_req = 1'b0; if_addr = 32'd0;
    mem_req = 1'b0; mem_we = 1'b0; mem_addr = 32'd0; mem_wdata = 32'd0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_if_ack", {31'd0, if_ack}, 32'd0);
    check("rst_mem_ack", {31'd0, mem_ack}, 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_mem_rdata", mem_rdata, 32'd0);
    check("rst_we_n", {31'd0, sram_we_n}, 32'd1);
    check("rst_addr", {13'd0, sram_addr}, 32'd0);
    check("rst_dq_hiz", sram_dq, PAT);
    check("rst_ready", {30'd0, if_ready, mem_ready}, 32'd3);
    next_drive();
    rst = 1'b1; mdl_clr = 1'b0; tb_pat = 1'b0;
    next_drive();

    // Fetch read of 0x10 -> word 4
    if_req = 1'b1; if_addr = 32'h10; c0 = cyc;
    push_exp(1'b1, 1'b1, 32'hC0DE_0004, c0 + 5);
    for (int k = 0; k <= 5; k++) begin
      if (k > 0) next_drive();
      @(negedge clk);
      check("f_if_ready", {31'd0, if_ready}, {31'd0, k == 5});
      if (k >= 1 && k <= 4) begin
        check("f_addr", {13'd0, sram_addr}, 32'h4);
        check("f_we_n", {31'd0, sram_we_n}, 32'd1);
      end
      if (k == 5) if_req = 1'b0;
    end
    next_drive();

    // Data write 0xDEADBEEF to 0x400 -> word 0x100
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h400; mem_wdata = 32'hDEAD_BEEF;
    tb_drv = 1'b0; c0 = cyc;
    push_exp(1'b0, 1'b0, 32'd0, c0 + 5);
    for (int k = 0; k <= 5; k++) begin
      if (k > 0) next_drive();
      if (k == 5) begin tb_drv = 1'b1; tb_pat = 1'b1; end
      @(negedge clk);
      if (k >= 1 && k <= 4) begin
        check("w_addr", {13'd0, sram_addr}, 32'h100);
        check("w_we_n", {31'd0, sram_we_n}, {31'd0, k == 4});
        check("w_dq", sram_dq, 32'hDEAD_BEEF);
      end
      if (k == 5) begin
        check("w_dq_release", sram_dq, PAT);
        check("w_we_n_done", {31'd0, sram_we_n}, 32'd1);
        mem_req = 1'b0; mem_we = 1'b0;
      end
    end
    check("w_model", mdl_mem[256], 32'hDEAD_BEEF);
    next_drive();
    tb_pat = 1'b0;

    // Simultaneous requests: data first, then fetch
    if_req = 1'b1; if_addr = 32'h20; mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h44;
    c0 = cyc;
    push_exp(1'b0, 1'b1, 32'hC0DE_0011, c0 + 5);
    push_exp(1'b1, 1'b1, 32'hC0DE_0008, c0 + 11);
    for (int k = 0; k <= 11; k++) begin
      if (k > 0) next_drive();
      @(negedge clk);
      check("s_if_ready", {31'd0, if_ready}, {31'd0, k == 11});
      if (k == 1) check("s_addr_data", {13'd0, sram_addr}, 32'h11);
      if (k == 7) check("s_addr_fetch", {13'd0, sram_addr}, 32'h8);
      if (mem_ack) mem_req = 1'b0;
      if (if_ack) if_req = 1'b0;
    end
    next_drive();

    // Reset in cycle 2 of a write aborts it
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h800; mem_wdata = 32'h1234_5678;
    tb_drv = 1'b0;
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) next_drive();
      if (k == 2) rst = 1'b0;
      if (k == 3) begin
        rst = 1'b1; mem_req = 1'b0; mem_we = 1'b0; tb_drv = 1'b1; tb_pat = 1'b1;
      end
      @(negedge clk);
      if (k == 1 || k == 2) check("r_we_n_active", {31'd0, sram_we_n}, 32'd0);
      if (k >= 3) begin
        check("r_we_n", {31'd0, sram_we_n}, 32'd1);
        check("r_dq_hiz", sram_dq, PAT);
        check("r_no_ack", {30'd0, if_ack, mem_ack}, 32'd0);
      end
      if (k == 3) begin
        check("r_if_rdata", if_rdata, 32'd0);
        check("r_mem_rdata", mem_rdata, 32'd0);
      end
    end
    next_drive();
    tb_pat = 1'b0;
    if_req = 1'b1; if_addr = 32'h10; c0 = cyc;
    push_exp(1'b1, 1'b1, 32'hC0DE_0004, c0 + 5);
    for (int k = 0; k <= 5; k++) begin
      if (k > 0) next_drive();
      @(negedge clk);
      if (if_ack) if_req = 1'b0;
    end
    next_drive();

    // Starvation: both held -> D, D, F, D, D, F
    if_req = 1'b1; if_addr = 32'h30; mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h400;
    c0 = cyc;
    push_exp(1'b0, 1'b1, 32'hDEAD_BEEF, c0 + 5);
    push_exp(1'b0, 1'b1, 32'hDEAD_BEEF, c0 + 11);
    push_exp(1'b1, 1'b1, 32'hC0DE_000C, c0 + 17);
    push_exp(1'b0, 1'b1, 32'hDEAD_BEEF, c0 + 23);
    push_exp(1'b0, 1'b1, 32'hDEAD_BEEF, c0 + 29);
    push_exp(1'b1, 1'b1, 32'hC0DE_000C, c0 + 35);
    for (int k = 0; k <= 35; k++) begin
      if (k > 0) next_drive();
      @(negedge clk);
      if (k == 13) check("st_addr_fetch", {13'd0, sram_addr}, 32'hC);
      if (k == 35) begin if_req = 1'b0; mem_req = 1'b0; end
    end
    next_drive();

    // Back-to-back data reads with mem_req held, address advanced per ack
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h10; c0 = cyc; nack = 0;
    push_exp(1'b0, 1'b1, 32'hC0DE_0004, c0 + 5);
    push_exp(1'b0, 1'b1, 32'hC0DE_0005, c0 + 11);
    push_exp(1'b0, 1'b1, 32'hDEAD_BEEF, c0 + 17);
    for (int k = 0; k <= 17; k++) begin
      if (k > 0) next_drive();
      @(negedge clk);
      check("b_mem_ready", {31'd0, mem_ready}, {31'd0, (k == 5) || (k == 11) || (k == 17)});
      if (mem_ack) begin
        nack++;
        if (nack == 1) mem_addr = 32'h14;
        else if (nack == 2) mem_addr = 32'h400;
        else mem_req = 1'b0;
      end
    end

    // Drain the scoreboard within a bounded number of cycles
    for (int k = 0; k < 20 && sb_q.size() > 0; k++) @(negedge clk);
    check("scoreboard_drain", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
